multiprecision_add_seq: RTL



---
 rtl/multiprecision_add_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multiprecision_add_seq.sv
// Wide adder built by time-multiplexing one N-bit carry-skip slice over
// SLICES cycles. Operands are latched on the input handshake, one slice is
// summed per cycle with a registered inter-slice carry, and the full result
// is held on the output handshake until the consumer takes it.

// One skip block: ripple inside, bypass the ripple when every bit propagates.
module csa_block #(
  parameter int BW = 4
) (
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  input  logic          i_cin,
  output logic [BW-1:0] o_sum,
  output logic          o_cout
);
  logic w_rip;
  logic w_prop;

  // Bit-serial ripple through the block; c is a local running carry.
  always_comb begin
    logic c;
    o_sum = '0;
    c     = i_cin;
    for (int k = 0; k < BW; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ c;
      c        = (i_a[k] & i_b[k]) | ((i_a[k] ^ i_b[k]) & c);
    end
    w_rip = c;
  end

  assign w_prop = &(i_a ^ i_b);
  assign o_cout = w_prop ? i_cin : w_rip;
endmodule

// N-bit carry-skip adder: a chain of skip blocks, last one may be narrower.
module carry_skip_adder #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;

  logic [NB:0] w_c;
  assign w_c[0] = i_cin;

  generate
    for (genvar g = 0; g < NB; g++) begin : g_blk
      localparam int LO = g * BLOCK_SIZE;
      localparam int BW = (LO + BLOCK_SIZE > N) ? (N - LO) : BLOCK_SIZE;
      csa_block #(.BW(BW)) u_blk (
        .i_a   (i_a[LO +: BW]),
        .i_b   (i_b[LO +: BW]),
        .i_cin (w_c[g]),
        .o_sum (o_sum[LO +: BW]),
        .o_cout(w_c[g+1])
      );
    end
  endgenerate

  assign o_cout = w_c[NB];
endmodule

module multiprecision_add_seq #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int SLICES     = 4,
  localparam int W         = N * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_op_a, r_op_b, r_sum;
  logic            r_carry, r_cout;
  logic [IW-1:0]   r_idx;
  logic [N-1:0]    w_sl_a, w_sl_b, w_sl_sum;
  logic            w_sl_cout;
  logic            w_last;
  logic            w_accept;

  assign w_sl_a   = r_op_a[r_idx*N +: N];
  assign w_sl_b   = r_op_b[r_idx*N +: N];
  assign w_last   = (r_idx == IW'(SLICES - 1));
  assign w_accept = (r_state == S_IDLE) && in_valid;

  carry_skip_adder #(.N(N), .BLOCK_SIZE(BLOCK_SIZE)) u_slice (
    .i_a   (w_sl_a),
    .i_b   (w_sl_b),
    .i_cin (r_carry),
    .o_sum (w_sl_sum),
    .o_cout(w_sl_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: accept in IDLE, step slices in RUN, wait for consumer in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // Datapath: latch operands on accept, fold one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[r_idx*N +: N] <= w_sl_sum;
      r_carry             <= w_sl_cout;
      r_idx               <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) r_cout  <= w_sl_cout;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
endmodule
